// File: rtl/calc_pkg.sv
// Shared constants and types for the hex calculator core:
// keycodes, operator encodings, multiplier control state.
package calc_pkg;

    localparam logic [4:0] KEY_CE  = 5'b00001;
    localparam logic [4:0] KEY_DEL = 5'b00010;
    localparam logic [4:0] KEY_CA  = 5'b00011;
    localparam logic [4:0] KEY_EQ  = 5'b00100;
    localparam logic [4:0] KEY_SQR = 5'b01100;

    localparam logic       KEY_DIGIT_PFX = 1'b1;
    localparam logic [2:0] KEY_OP_PFX    = 3'b010;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_ADD  = 2'b01,
        OP_MUL  = 2'b10,
        OP_SUB  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        MS_IDLE = 2'b00,
        MS_MUL  = 2'b01,
        MS_DONE = 2'b10
    } mstate_e;

    // What to do with the product once the multiplier finishes
    typedef enum logic [1:0] {
        MK_EQ    = 2'b00,
        MK_CHAIN = 2'b01,
        MK_SQR   = 2'b10
    } mkind_e;

endpackage

// File: rtl/calc_seq_mult.sv
// Shift-add multiplier: start/a/b in, product[2W-1:0] out.
// One partial product per cycle, W cycles; done pulses when product is final.
module calc_seq_mult #(
    parameter int W = 16
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] mc_q, mc_d;
    logic [W-1:0]   mp_q, mp_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           run_q, run_d;
    logic           done_q, done_d;

    // The start cycle already accumulates bit 0, so W-1 more remain.
    always_comb begin
        acc_d  = acc_q;
        mc_d   = mc_q;
        mp_d   = mp_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start) begin
            acc_d = b[0] ? {{W{1'b0}}, a} : '0;
            mc_d  = {{(W-1){1'b0}}, a, 1'b0};
            mp_d  = b >> 1;
            cnt_d = CW'(1);
            run_d = 1'b1;
        end else if (run_q) begin
            acc_d = acc_q + (mp_q[0] ? mc_q : '0);
            mc_d  = mc_q << 1;
            mp_d  = mp_q >> 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q  <= '0;
            mc_q   <= '0;
            mp_q   <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            mc_q   <= mc_d;
            mp_q   <= mp_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done    = done_q;
    assign product = acc_q;

endmodule

// File: rtl/calc_core_param.sv
// NDIG-digit hex calculator core: key handling, X/Y/op/overflow registers,
// add/sub datapath, chained operators and a multi-cycle multiplier.
// Ports: clock, reset, newkey, keycode[4:0] in; key_ready, key_dropped,
//        busy, value_out[W-1:0], overflow out.
module calc_core_param
    import calc_pkg::*;
#(
    parameter int NDIG = 4,
    localparam int W = 4 * NDIG
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         newkey,
    input  logic [4:0]   keycode,
    output logic         key_ready,
    output logic         key_dropped,
    output logic         busy,
    output logic [W-1:0] value_out,
    output logic         overflow
);

    logic [W-1:0] x_q, x_d, y_q, y_d;
    op_e          op_q, op_d, mop_q, mop_d;
    mkind_e       mk_q, mk_d;
    mstate_e      st_q, st_d;
    logic         ovf_q, ovf_d, ld_q, ld_d, drop_q, drop_d;

    logic           accept, mul_start, mul_done;
    logic [W-1:0]   mul_a, mul_b;
    logic [2*W-1:0] mul_p;

    logic         is_dig, is_op, is_ce, is_del, is_ca, is_eq, is_sqr;
    logic [3:0]   dig;
    op_e          kop;
    logic [W:0]   sum;
    logic [W-1:0] res;
    logic         res_ov;

    assign is_dig = keycode[4] == KEY_DIGIT_PFX;
    assign is_op  = (keycode[4:2] == KEY_OP_PFX) && (keycode[1:0] != 2'b00);
    assign is_ce  = keycode == KEY_CE;
    assign is_del = keycode == KEY_DEL;
    assign is_ca  = keycode == KEY_CA;
    assign is_eq  = keycode == KEY_EQ;
    assign is_sqr = keycode == KEY_SQR;
    assign dig    = keycode[3:0];
    assign kop    = op_e'(keycode[1:0]);

    // Pending add/sub evaluated on Y (left) and X (right)
    assign sum    = {1'b0, y_q} + {1'b0, x_q};
    assign res    = (op_q == OP_SUB) ? (y_q - x_q) : sum[W-1:0];
    assign res_ov = (op_q == OP_SUB) ? (y_q < x_q) : sum[W];

    // Multiplier control FSM
    always_ff @(posedge clock) begin
        if (reset) st_q <= MS_IDLE;
        else       st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            MS_IDLE: if (mul_start) st_d = MS_MUL;
            MS_MUL:  if (mul_done)  st_d = MS_DONE;
            MS_DONE: st_d = MS_IDLE;
            default: st_d = MS_IDLE;
        endcase
    end

    always_comb begin
        busy      = st_q != MS_IDLE;
        key_ready = ~busy;
        accept    = newkey & key_ready;
    end

    // Register datapath
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        op_d      = op_q;
        ovf_d     = ovf_q;
        ld_d      = ld_q;
        mk_d      = mk_q;
        mop_d     = mop_q;
        mul_start = 1'b0;
        mul_a     = y_q;
        mul_b     = x_q;
        drop_d    = newkey & busy;
        if (st_q == MS_DONE) begin
            x_d   = mul_p[W-1:0];
            ovf_d = ovf_q | (|mul_p[2*W-1:W]);
            case (mk_q)
                MK_EQ: begin
                    y_d  = '0;
                    op_d = OP_NONE;
                end
                MK_CHAIN: begin
                    y_d  = mul_p[W-1:0];
                    op_d = mop_q;
                end
                default: ;
            endcase
        end else if (accept) begin
            ld_d = 1'b0;
            unique case (1'b1)
                is_dig: begin
                    ld_d = 1'b1;
                    if (!ld_q)
                        x_d = {{(W-4){1'b0}}, dig};
                    else if (x_q[W-1:W-4] == 4'h0)
                        x_d = {x_q[W-5:0], dig};
                end
                is_ce: begin
                    x_d   = '0;
                    ovf_d = 1'b0;
                end
                is_del: x_d = {4'h0, x_q[W-1:4]};
                is_ca: begin
                    x_d   = '0;
                    y_d   = '0;
                    op_d  = OP_NONE;
                    ovf_d = 1'b0;
                end
                is_eq: begin
                    case (op_q)
                        OP_ADD, OP_SUB: begin
                            x_d   = res;
                            ovf_d = ovf_q | res_ov;
                            y_d   = '0;
                            op_d  = OP_NONE;
                        end
                        OP_MUL: begin
                            mul_start = 1'b1;
                            mk_d      = MK_EQ;
                        end
                        default: begin
                            y_d  = '0;
                            op_d = OP_NONE;
                        end
                    endcase
                end
                is_sqr: begin
                    mul_a     = x_q;
                    mul_start = 1'b1;
                    mk_d      = MK_SQR;
                end
                is_op: begin
                    if (op_q != OP_NONE && ld_q) begin
                        if (op_q == OP_MUL) begin
                            mul_start = 1'b1;
                            mk_d      = MK_CHAIN;
                            mop_d     = kop;
                        end else begin
                            x_d   = res;
                            y_d   = res;
                            op_d  = kop;
                            ovf_d = ovf_q | res_ov;
                        end
                    end else begin
                        y_d  = x_q;
                        op_d = kop;
                    end
                end
                // unassigned codes leave everything, including last_digit
                default: ld_d = ld_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_q    <= '0;
            y_q    <= '0;
            op_q   <= OP_NONE;
            ovf_q  <= 1'b0;
            ld_q   <= 1'b0;
            drop_q <= 1'b0;
            mk_q   <= MK_EQ;
            mop_q  <= OP_NONE;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            op_q   <= op_d;
            ovf_q  <= ovf_d;
            ld_q   <= ld_d;
            drop_q <= drop_d;
            mk_q   <= mk_d;
            mop_q  <= mop_d;
        end
    end

    calc_seq_mult #(.W(W)) u_mult (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .a       (mul_a),
        .b       (mul_b),
        .done    (mul_done),
        .product (mul_p)
    );

    assign value_out   = x_q;
    assign overflow    = ovf_q;
    assign key_dropped = drop_q;

endmodule

// File: tb/tb_calc_core_param.sv
// Bench for calc_core_param: directed key sequences with literal results
// plus random key streams checked cycle by cycle against a behavioural model.
module tb_calc_core_param;

    localparam int NDIG = 4;
    localparam int W = 4 * NDIG;
    localparam longint MOD = 64'd1 << W;

    localparam logic [4:0] K_CE  = 5'b00001;
    localparam logic [4:0] K_DEL = 5'b00010;
    localparam logic [4:0] K_CA  = 5'b00011;
    localparam logic [4:0] K_EQ  = 5'b00100;
    localparam logic [4:0] K_SQR = 5'b01100;
    localparam logic [4:0] K_ADD = 5'b01001;
    localparam logic [4:0] K_MUL = 5'b01010;
    localparam logic [4:0] K_SUB = 5'b01011;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         newkey = 1'b0;
    logic [4:0]   keycode = 5'b0;
    logic         key_ready, key_dropped, busy, overflow;
    logic [W-1:0] value_out;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clock = ~clock;

    calc_core_param #(.NDIG(NDIG)) dut (
        .clock       (clock),
        .reset       (reset),
        .newkey      (newkey),
        .keycode     (keycode),
        .key_ready   (key_ready),
        .key_dropped (key_dropped),
        .busy        (busy),
        .value_out   (value_out),
        .overflow    (overflow)
    );

    task automatic check(input string name, input longint act,
                         input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint mx, my, pprod;
    int     mop, pnew, pkind, mbusy;
    bit     movf, mld, mdrop;

    // result of "y op x" for add/sub, as calculator arithmetic
    task automatic arith(input int op, input longint y, input longint x,
                         output longint r, output bit of);
        if (op == 1) begin
            r  = (y + x) % MOD;
            of = (y + x) >= MOD;
        end else begin
            r  = (y - x + MOD) % MOD;
            of = y < x;
        end
    endtask

    task automatic start_mul(input int kind, input longint a,
                             input longint b, input int nop);
        pkind = kind;
        pnew  = nop;
        pprod = a * b;
        mbusy = W + 1;
    endtask

    task automatic finish_mul();
        mx = pprod % MOD;
        if (pprod >= MOD) movf = 1'b1;
        if (pkind == 0) begin
            my  = 0;
            mop = 0;
        end else if (pkind == 1) begin
            my  = pprod % MOD;
            mop = pnew;
        end
    endtask

    task automatic do_key(input logic [4:0] k);
        longint r;
        bit of;
        if (k[4]) begin
            if (!mld) mx = longint'(k[3:0]);
            else if (mx < (MOD / 16)) mx = mx * 16 + longint'(k[3:0]);
            mld = 1'b1;
        end else if (k == K_CE) begin
            mx = 0; movf = 0; mld = 0;
        end else if (k == K_DEL) begin
            mx = mx / 16; mld = 0;
        end else if (k == K_CA) begin
            mx = 0; my = 0; mop = 0; movf = 0; mld = 0;
        end else if (k == K_EQ) begin
            mld = 0;
            if (mop == 2) start_mul(0, my, mx, 0);
            else if (mop == 0) my = 0;
            else begin
                arith(mop, my, mx, r, of);
                mx = r; movf |= of; my = 0; mop = 0;
            end
        end else if (k == K_SQR) begin
            mld = 0;
            start_mul(2, mx, mx, 0);
        end else if (k[4:2] == 3'b010 && k[1:0] != 2'b00) begin
            if (mop != 0 && mld) begin
                if (mop == 2) start_mul(1, my, mx, int'(k[1:0]));
                else begin
                    arith(mop, my, mx, r, of);
                    mx = r; my = r; movf |= of; mop = int'(k[1:0]);
                end
            end else begin
                my = mx; mop = int'(k[1:0]);
            end
            mld = 0;
        end
    endtask

    always @(posedge clock) begin
        if (reset) begin
            mx = 0; my = 0; mop = 0; movf = 0; mld = 0;
            mbusy = 0; mdrop = 0;
        end else begin
            mdrop = newkey && (mbusy > 0);
            if (mbusy > 0) begin
                mbusy--;
                if (mbusy == 0) finish_mul();
            end else if (newkey) begin
                do_key(keycode);
            end
        end
    end

    // every-cycle comparison against the model
    always @(negedge clock) begin
        if (chk_en) begin
            check("value_out", longint'(value_out), mx);
            check("overflow", longint'(overflow), longint'(movf));
            check("busy", longint'(busy), longint'(mbusy > 0));
            check("key_ready", longint'(key_ready), longint'(mbusy == 0));
            check("key_dropped", longint'(key_dropped), longint'(mdrop));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic press(input logic [4:0] k);
        @(posedge clock);
        #1;
        newkey  = 1'b1;
        keycode = k;
        @(posedge clock);
        #1;
        newkey = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("idle_timeout", longint'(busy), 0);
    endtask

    function automatic logic [4:0] rand_key();
        int r = int'($urandom_range(0, 99));
        logic [4:0] ign [7] = '{5'd0, 5'd5, 5'd6, 5'd7, 5'd13, 5'd14, 5'd15};
        if (r < 42) return {1'b1, 4'($urandom_range(0, 15))};
        if (r < 52) return K_ADD;
        if (r < 60) return K_MUL;
        if (r < 66) return K_SUB;
        if (r < 78) return K_EQ;
        if (r < 83) return K_SQR;
        if (r < 88) return K_CE;
        if (r < 92) return K_DEL;
        if (r < 95) return K_CA;
        return ign[$urandom_range(0, 6)];
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        check("rst_value", longint'(value_out), 0);
        check("rst_overflow", longint'(overflow), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_key_ready", longint'(key_ready), 1);
        check("rst_key_dropped", longint'(key_dropped), 0);

        // digit entry, 5th digit ignored, DEL, CE
        for (int d = 1; d <= 5; d++) press({1'b1, 4'(d)});
        check("digits_1234", longint'(value_out), 64'h1234);
        press(K_DEL);
        check("del_0123", longint'(value_out), 64'h0123);
        press(K_CE);
        check("ce_zero", longint'(value_out), 0);

        // 7 + 5 =
        press(5'h17); press(K_ADD); press(5'h15); press(K_EQ);
        check("add_000c", longint'(value_out), 64'h000C);

        // FFFF + 2 = overflow, sticky until CE
        press(K_CE);
        repeat (4) press(5'h1F);
        press(K_ADD); press(5'h12); press(K_EQ);
        check("add_wrap", longint'(value_out), 64'h0001);
        check("add_ovf", longint'(overflow), 1);
        press(5'h13);
        check("ovf_sticky", longint'(overflow), 1);
        press(K_CE);
        check("ce_clr_ovf", longint'(overflow), 0);

        // 3 - 5 =
        press(5'h13); press(K_SUB); press(5'h15); press(K_EQ);
        check("sub_fffe", longint'(value_out), 64'hFFFE);
        check("sub_ovf", longint'(overflow), 1);
        press(K_CA);

        // 2 + 3 * 4 = chained
        press(5'h12); press(K_ADD); press(5'h13); press(K_MUL);
        check("chain_5", longint'(value_out), 64'h0005);
        press(5'h14); press(K_EQ);
        wait_idle();
        check("chain_14", longint'(value_out), 64'h0014);

        // 0100 * 0100 = : busy W+1 cycles, overflow
        press(K_CA);
        press(5'h11); press(5'h10); press(5'h10); press(K_MUL);
        press(5'h11); press(5'h10); press(5'h10); press(K_EQ);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(posedge clock);
            #1;
        end
        check("mul_busy_cycles", longint'(n), 17);
        check("mul_low", longint'(value_out), 0);
        check("mul_ovf", longint'(overflow), 1);

        // 12 SQR with a key dropped while busy
        press(K_CE);
        press(5'h11); press(5'h12); press(K_SQR);
        press(5'h17);
        check("drop_pulse", longint'(key_dropped), 1);
        @(posedge clock);
        #1;
        check("drop_one_cycle", longint'(key_dropped), 0);
        wait_idle();
        check("sqr_144", longint'(value_out), 64'h0144);

        // reset aborts a running multiply
        press(5'h11); press(K_SUB); press(5'h12); press(K_EQ);
        press(K_SQR);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("abort_value", longint'(value_out), 0);
        check("abort_busy", longint'(busy), 0);
        check("abort_ready", longint'(key_ready), 1);
        check("abort_ovf", longint'(overflow), 0);

        // random key streams against the model
        for (int i = 0; i < 4000; i++) begin
            @(posedge clock);
            #1;
            reset   = ($urandom_range(0, 299) == 0);
            newkey  = ($urandom_range(0, 1) == 1);
            keycode = rand_key();
        end
        @(posedge clock);
        #1;
        newkey = 1'b0;
        reset  = 1'b0;
        repeat (W + 4) @(posedge clock);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
